// File: rtl/seq_divider.sv
// Iterative restoring divider (RISC-V DIV/DIVU/REM/REMU semantics), one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: skip the iteration for divide-by-zero, signed overflow and |dividend| < |divisor|.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] qsh_q, qsh_d;       // dividend magnitude shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             in_neg_dvd, in_neg_dvs, in_zero, in_ovf;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   r_sh;
  logic             r_ge;

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly, so negating the most-negative value is safe.
  always_comb begin
    in_neg_dvd = op_signed & dividend[WIDTH-1];
    in_neg_dvs = op_signed & divisor[WIDTH-1];
    dvd_mag    = in_neg_dvd ? (~dividend + ONE_W) : dividend;
    dvs_mag    = in_neg_dvs ? (~divisor + ONE_W) : divisor;
    in_zero    = (divisor == '0);
    in_ovf     = op_signed & (dividend == MIN_NEG) & (divisor == '1);
  end

  // The compare is done on WIDTH+1 bits; the difference always fits back into WIDTH bits.
  always_comb begin
    r_sh = {rem_q, qsh_q[WIDTH-1]};
    r_ge = (r_sh >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    qsh_d     = qsh_q;
    dvs_d     = dvs_q;
    dvd_raw_d = dvd_raw_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = in_neg_dvd;
          zero_d    = in_zero;
          ovf_d     = in_ovf;
          dvd_raw_d = dividend;
          dvs_d     = dvs_mag;
          qsh_d     = dvd_mag;
          rem_d     = '0;
          cnt_d     = '0;
          quo_d     = '0;
          rmd_d     = '0;
          dbz_d     = 1'b0;
          state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (in_zero || in_ovf || (dvd_mag < dvs_mag)) begin
            // Preload Q = 0, R = |dividend| so FIX's sign step yields remainder = dividend.
            rem_d   = dvd_mag;
            qsh_d   = '0;
            state_d = FIX;
          end
`endif
        end
      end

      CALC: begin
        rem_d = r_ge ? (r_sh[WIDTH-1:0] - dvs_q) : r_sh[WIDTH-1:0];
        qsh_d = {qsh_q[WIDTH-2:0], r_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quo_d = '1;
          rmd_d = dvd_raw_q;
          dbz_d = 1'b1;
        end else if (ovf_q) begin
          quo_d = MIN_NEG;
          rmd_d = '0;
        end else begin
          quo_d = neg_quo_q ? (~qsh_q + ONE_W) : qsh_q;
          rmd_d = neg_rem_q ? (~rem_q + ONE_W) : rem_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      qsh_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      qsh_q     <= qsh_d;
      dvs_q     <= dvs_d;
      dvd_raw_q <= dvd_raw_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed vectors, handshake corner cases, reset abort, small random sweep.
module tb_seq_divider;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_BUILD = 1'b1;
`else
  localparam bit EARLY_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_signed  (op_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic early);
    return (EARLY_BUILD && early) ? 2 : W + 2;
  endfunction

  // Positioned at the first negedge after the accepting edge (cycle T+1); inj > 0 pulses a start in that cycle.
  task automatic wait_done(input int inj, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (c == inj) begin
        start = 1'b1; op_signed = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op_signed = sgn; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; op_signed = ~sgn; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz, input logic early);
    int lat, bc;
    launch(sgn, a, b);
    wait_done(0, lat, bc);
    chk({tag, "/lat"},  W'(lat), W'(exp_lat(early)));
    chk({tag, "/busy"}, W'(bc),  W'(exp_lat(early) - 1));
    chk({tag, "/q"},    quotient,  eq);
    chk({tag, "/r"},    remainder, er);
    chk({tag, "/dbz"},  W'(div_by_zero), W'(edbz));
  endtask

  initial begin
    int lat, bc, dones;
    logic [W-1:0] a, b, am, bm, eq, er;
    logic sgn, edbz, early;

    rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst/busy", W'(busy), '0);
    chk("rst/done", W'(done), '0);
    chk("rst/q", quotient, '0);
    chk("rst/r", remainder, '0);
    chk("rst/dbz", W'(div_by_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("u100_7",   1'b0, 32'd100,       32'd7,        32'd14,        32'd2,        1'b0, 1'b0);
    do_op("sm7_2",    1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("s7_m2",    1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 1'b0);
    do_op("sm7_m2",   1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,         32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("sm100_7",  1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0, 1'b0);
    do_op("sdz",      1'b1, 32'h12345678,  32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b1, 1'b1);
    do_op("udz",      1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b1, 1'b1);
    do_op("sovf",     1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 1'b1);
    do_op("uovf",     1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,         32'h80000000, 1'b0, 1'b1);
    do_op("smin_2",   1'b1, 32'h80000000,  32'd2,        32'hC0000000,  32'd0,        1'b0, 1'b0);
    do_op("umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 1'b0);
    do_op("s5_10",    1'b1, 32'd5,         32'd10,       32'd0,         32'd5,        1'b0, 1'b1);
    do_op("u1000_33", 1'b0, 32'd1000,      32'd33,       32'd30,        32'd10,       1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("hold/q", quotient, 32'd30);
    chk("hold/r", remainder, 32'd10);

    // start while busy is ignored; start in the done cycle is accepted
    launch(1'b0, 32'd100, 32'd7);
    wait_done(10, lat, bc);
    chk("hs1/lat", W'(lat), W'(W + 2));
    chk("hs1/q", quotient, 32'd14);
    chk("hs1/r", remainder, 32'd2);
    start = 1'b1; op_signed = 1'b0; dividend = 32'd1000; divisor = 32'd33;
    @(negedge clk);
    start = 1'b0; dividend = 32'd9; divisor = 32'd9;
    chk("hs2/busy", W'(busy), W'(1));
    chk("hs2/clr_q", quotient, '0);
    chk("hs2/clr_r", remainder, '0);
    wait_done(0, lat, bc);
    chk("hs2/lat", W'(lat), W'(W + 2));
    chk("hs2/q", quotient, 32'd30);
    chk("hs2/r", remainder, 32'd10);

    // reset in the middle of an operation aborts it
    do_op("pre_rst", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1);
    launch(1'b0, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    chk("mid/busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("abort/busy", W'(busy), '0);
    chk("abort/done", W'(done), '0);
    chk("abort/q", quotient, '0);
    chk("abort/r", remainder, '0);
    chk("abort/dbz", W'(div_by_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort/quiet", W'(dones), '0);
    do_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    // random sweep against native-operator reference
    for (int i = 0; i < 200; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (i % 4 == 0) b = b >> $urandom_range(0, 31);
      if (i % 16 == 1) b = '0;
      if (i % 32 == 2) begin a = 32'h80000000; b = '1; sgn = 1'b1; end
      am   = (sgn && a[W-1]) ? -a : a;
      bm   = (sgn && b[W-1]) ? -b : b;
      edbz = (b == '0);
      if (edbz) begin
        eq = '1; er = a;
      end else if (sgn && a == 32'h80000000 && b == '1) begin
        eq = a; er = '0;
      end else if (sgn) begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end else begin
        eq = a / b;
        er = a % b;
      end
      early = edbz || (sgn && a == 32'h80000000 && b == '1) || (am < bm);
      do_op($sformatf("rnd%0d", i), sgn, a, b, eq, er, edbz, early);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
